mv_pwm_driver: RTL and testbench

MV_PWM_DRIVER -- requirements
Module: mv_pwm_driver

---
 rtl/mv_pwm_pkg.sv | 19 +
 rtl/mv_pwm_driver_mv_scaler.sv | 41 ++++
 rtl/mv_pwm_driver.sv | 128 ++++++++++++
 tb/tb_mv_pwm_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mv_pwm_pkg.sv
// Shared definitions for the MV-to-PWM driver.
//   state_t          : 2-bit driver state encoding (IDLE=0, RUN=1, HOLD=2, FAULT=3)
//   PWM_W_DEF        : default PWM counter / duty width
//   MV_SHIFT_DEF     : default right shift applied to |MV|
//   FAULT_LIMIT_DEF  : default number of consecutive overflowed samples that trips FAULT
package mv_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int PWM_W_DEF       = 10;
    localparam int MV_SHIFT_DEF    = 8;
    localparam int FAULT_LIMIT_DEF = 4;

endpackage

// File: rtl/mv_pwm_driver_mv_scaler.sv
// mv_scaler: combinational magnitude scaling of the PID manipulation value.
//   mv          : signed 32-bit manipulation value
//   mag_clamped : (|mv| >> MV_SHIFT) clamped to 2^PWM_W-1
//   sat         : 1 when the clamp was applied
module mv_scaler
    import mv_pwm_pkg::*;
#(
    parameter int PWM_W    = PWM_W_DEF,
    parameter int MV_SHIFT = MV_SHIFT_DEF
) (
    input  logic signed [31:0]      mv,
    output logic        [PWM_W-1:0] mag_clamped,
    output logic                    sat
);

    localparam logic [31:0] MAG_LIMIT = 32'((64'd1 << PWM_W) - 64'd1);

    // Unsigned result so that the most negative input maps to 2^31.
    function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        return v[31] ? (~u + 32'd1) : u;
    endfunction

    function automatic logic clamp_hit(input logic [31:0] m);
        return m > MAG_LIMIT;
    endfunction

    function automatic logic [PWM_W-1:0] clamp_mag(input logic [31:0] m);
        return clamp_hit(m) ? MAG_LIMIT[PWM_W-1:0] : m[PWM_W-1:0];
    endfunction

    logic [31:0] mag_shifted;

    always_comb begin
        mag_shifted = abs_mag(mv) >> MV_SHIFT;
        mag_clamped = clamp_mag(mag_shifted);
        sat         = clamp_hit(mag_shifted);
    end

endmodule

// File: rtl/mv_pwm_driver.sv
// mv_pwm_driver: converts the PID manipulation value into a sign/magnitude PWM drive.
//   clk, rst     : clock and synchronous active-low reset
//   en           : run enable
//   mv, of       : signed manipulation value and PID overflow flags, used only at the sample point
//   fault_clr    : leaves FAULT towards IDLE
//   pwm, dir     : PWM drive and direction (1 = negative MV)
//   duty         : currently applied duty
//   period_start : high while cnt==0 in RUN or HOLD
//   sat          : applied duty came from a clamped sample
//   fault        : high in FAULT
//   state        : IDLE=0, RUN=1, HOLD=2, FAULT=3
module mv_pwm_driver
    import mv_pwm_pkg::*;
#(
    parameter int PWM_W       = PWM_W_DEF,
    parameter int MV_SHIFT    = MV_SHIFT_DEF,
    parameter int FAULT_LIMIT = FAULT_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [31:0]      mv,
    input  logic        [2:0]       of,
    input  logic                    fault_clr,
    output logic                    pwm,
    output logic                    dir,
    output logic        [PWM_W-1:0] duty,
    output logic                    period_start,
    output logic                    sat,
    output logic                    fault,
    output logic        [1:0]       state
);

    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] CNT_ONE = 1;

    state_t           st;
    logic [PWM_W-1:0] cnt;
    logic [3:0]       ovf_cnt;

    logic [PWM_W-1:0] mag_clamped;
    logic             mv_sat;
    logic             active;
    logic             sample_pt;
    logic             bad_sample;
    logic [4:0]       ovf_inc;
    logic             trip;

    mv_scaler #(
        .PWM_W    (PWM_W),
        .MV_SHIFT (MV_SHIFT)
    ) u_scaler (
        .mv          (mv),
        .mag_clamped (mag_clamped),
        .sat         (mv_sat)
    );

    always_comb begin
        active     = (st == ST_RUN) || (st == ST_HOLD);
        sample_pt  = active && (cnt == CNT_MAX);
        bad_sample = (of != 3'b000);
        ovf_inc    = {1'b0, ovf_cnt} + 5'd1;
        // A tripping sample outranks en=0 in the same cycle.
        trip       = sample_pt && bad_sample && (ovf_inc >= 5'(FAULT_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st      <= ST_IDLE;
            cnt     <= '0;
            duty    <= '0;
            dir     <= 1'b0;
            sat     <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    cnt  <= '0;
                    duty <= '0;
                    if (en) st <= ST_RUN;
                end
                ST_RUN, ST_HOLD: begin
                    if (trip) begin
                        st      <= ST_FAULT;
                        cnt     <= '0;
                        duty    <= '0;
                        dir     <= 1'b0;
                        sat     <= 1'b0;
                        ovf_cnt <= '0;
                    end else if (!en) begin
                        st      <= ST_IDLE;
                        cnt     <= '0;
                        duty    <= '0;
                        dir     <= 1'b0;
                        sat     <= 1'b0;
                        ovf_cnt <= '0;
                    end else begin
                        // Loading at cnt==max makes the new duty take effect exactly at cnt==0.
                        cnt <= cnt + CNT_ONE;
                        if (sample_pt) begin
                            if (!bad_sample) begin
                                duty    <= mag_clamped;
                                dir     <= mv[31];
                                sat     <= mv_sat;
                                ovf_cnt <= '0;
                                st      <= ST_RUN;
                            end else begin
                                ovf_cnt <= ovf_inc[3:0];
                                st      <= ST_HOLD;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    cnt <= '0;
                    if (fault_clr) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign pwm          = active && (cnt < duty);
    assign period_start = active && (cnt == '0);
    assign fault        = (st == ST_FAULT);
    assign state        = st;

endmodule

// File: tb/tb_mv_pwm_driver.sv
// Directed bench for mv_pwm_driver at PWM_W=10, MV_SHIFT=8, FAULT_LIMIT=4.
module tb_mv_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] mv;
    logic [2:0]  of;
    logic        fault_clr;
    logic        pwm;
    logic        dir;
    logic [9:0]  duty;
    logic        period_start;
    logic        sat;
    logic        fault;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    mv_pwm_driver #(
        .PWM_W       (10),
        .MV_SHIFT    (8),
        .FAULT_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mv           (mv),
        .of           (of),
        .fault_clr    (fault_clr),
        .pwm          (pwm),
        .dir          (dir),
        .duty         (duty),
        .period_start (period_start),
        .sat          (sat),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called with cnt==0 observed; junk on mv/of mid-period must be ignored.
    task automatic sample(input logic [31:0] m, input logic [2:0] o);
        mv = $urandom;
        of = 3'($urandom);
        tick(1023);
        mv = m;
        of = o;
        tick(1);
        mv = $urandom;
        of = 3'($urandom);
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] st_e, input logic [9:0] duty_e,
                                 input logic dir_e, input logic sat_e, input logic pwm_e);
        check({tag, "_state"}, 32'(state), 32'(st_e));
        check({tag, "_duty"},  32'(duty),  32'(duty_e));
        check({tag, "_dir"},   32'(dir),   32'(dir_e));
        check({tag, "_sat"},   32'(sat),   32'(sat_e));
        check({tag, "_pwm"},   32'(pwm),   32'(pwm_e));
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; mv = '0; of = '0; fault_clr = 1'b0;
        tick(2);
        check_outputs("reset", 2'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("reset_ps",    32'(period_start), 32'd0);
        check("reset_fault", 32'(fault),        32'd0);

        // Start: first period runs at duty 0.
        rst = 1'b1; en = 1'b1; mv = 32'h0000_6400;
        tick(1);
        check_outputs("start", 2'd1, 10'd0, 1'b0, 1'b0, 1'b0);
        check("start_ps", 32'(period_start), 32'd1);
        sample(32'h0000_6400, 3'b000);
        check_outputs("pos100", 2'd1, 10'd100, 1'b0, 1'b0, 1'b1);
        check("pos100_ps", 32'(period_start), 32'd1);
        tick(99);
        check("pwm_cnt99", 32'(pwm), 32'd1);
        tick(1);
        check("pwm_cnt100", 32'(pwm), 32'd0);
        check("ps_cnt100", 32'(period_start), 32'd0);
        n = 0;
        while (!period_start && n < 1100) begin
            tick(1);
            n++;
        end
        check("period_gap", 32'(n), 32'd924);

        sample(32'hFFFF_9C00, 3'b000);
        check_outputs("neg100", 2'd1, 10'd100, 1'b1, 1'b0, 1'b1);
        sample(32'h0003_FF00, 3'b000);
        check_outputs("edge1023", 2'd1, 10'd1023, 1'b0, 1'b0, 1'b1);
        sample(32'h7FFF_FFFF, 3'b000);
        check_outputs("maxpos", 2'd1, 10'd1023, 1'b0, 1'b1, 1'b1);
        tick(1022);
        check("pwm_cnt1022", 32'(pwm), 32'd1);
        tick(1);
        check("pwm_cnt1023", 32'(pwm), 32'd0);
        mv = 32'h8000_0000; of = 3'b000;
        tick(1);
        check_outputs("minneg", 2'd1, 10'd1023, 1'b1, 1'b1, 1'b1);

        // Three overflowed samples hold the previous duty.
        for (int i = 0; i < 3; i++) begin
            sample(32'h0000_6400, 3'b010);
            check_outputs($sformatf("hold%0d", i), 2'd2, 10'd1023, 1'b1, 1'b1, 1'b1);
        end
        check("hold_ps", 32'(period_start), 32'd1);
        sample(32'h0000_6400, 3'b000);
        check_outputs("recover", 2'd1, 10'd100, 1'b0, 1'b0, 1'b1);

        // Counter was cleared: three more bad samples still HOLD, the fourth trips.
        for (int i = 0; i < 3; i++) sample(32'h0000_C800, 3'b001);
        check_outputs("hold_again", 2'd2, 10'd100, 1'b0, 1'b0, 1'b1);
        sample(32'h0000_C800, 3'b100);
        check_outputs("fault", 2'd3, 10'd0, 1'b0, 1'b0, 1'b0);
        check("fault_flag", 32'(fault), 32'd1);
        tick(5);
        check("fault_stays", 32'(state), 32'd3);
        check("fault_ps", 32'(period_start), 32'd0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("clr_idle", 32'(state), 32'd0);
        check("clr_fault", 32'(fault), 32'd0);
        tick(1);
        check_outputs("rerun", 2'd1, 10'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-period with duty 300, dir 1.
        sample(32'hFFFE_D400, 3'b000);
        check_outputs("d300", 2'd1, 10'd300, 1'b1, 1'b0, 1'b1);
        tick(299);
        check("pwm_cnt299", 32'(pwm), 32'd1);
        tick(201);
        check("pwm_cnt500", 32'(pwm), 32'd0);
        rst = 1'b0;
        tick(1);
        check_outputs("midrst", 2'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("midrst_ps",    32'(period_start), 32'd0);
        check("midrst_fault", 32'(fault),        32'd0);
        rst = 1'b1;
        tick(1);
        check_outputs("postrst", 2'd1, 10'd0, 1'b0, 1'b0, 1'b0);

        // en=0 mid-period.
        sample(32'hFFFF_9C00, 3'b000);
        tick(50);
        check("pwm_cnt50", 32'(pwm), 32'd1);
        en = 1'b0;
        tick(1);
        check_outputs("en_off", 2'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("en_off_ps", 32'(period_start), 32'd0);

        // en=0 beats a clean sample point.
        en = 1'b1;
        tick(1);
        mv = $urandom;
        tick(1023);
        mv = 32'h0000_6400; of = 3'b000; en = 1'b0;
        tick(1);
        check_outputs("en_vs_sample", 2'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        // A tripping sample beats en=0.
        en = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) sample(32'h0000_6400, 3'b001);
        check("pre_trip", 32'(state), 32'd2);
        tick(1023);
        of = 3'b100; en = 1'b0;
        tick(1);
        check("trip_vs_en", 32'(state), 32'd3);
        check("trip_vs_en_fault", 32'(fault), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
